// File: rtl/tug_referee.sv
// Round/match controller for the tug-of-war field: gates and arbitrates presses,
// scores round wins at the field ends, freezes and re-centres the field, latches the winner.
module tug_referee #(
    parameter int HOLD_CYCLES  = 8,
    parameter int MATCH_POINTS = 7,
    parameter int SCORE_W      = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               L,
    input  logic               R,
    input  logic               leftEnd,
    input  logic               rightEnd,
    output logic               fieldL,
    output logic               fieldR,
    output logic               fieldReset,
    output logic [SCORE_W-1:0] leftScore,
    output logic [SCORE_W-1:0] rightScore,
    output logic [1:0]         winner,
    output logic               playing
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SCORE_W-1:0] MATCH_PTS = SCORE_W'(MATCH_POINTS);

    typedef enum logic [1:0] {
        START = 2'd0,
        PLAY  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state, w_state_next;
    logic [HOLD_W-1:0]   r_hold, w_hold_next;
    logic [SCORE_W-1:0]  r_lscore, w_lscore_next, w_lscore_inc;
    logic [SCORE_W-1:0]  r_rscore, w_rscore_next, w_rscore_inc;
    logic [1:0]          r_winner, w_winner_next;
    logic                w_in_play, w_lpush, w_rpush, w_lpoint, w_rpoint;

    // Simultaneous presses cancel, so at most one push (and one point) per cycle.
    assign w_in_play    = (r_state == PLAY);
    assign w_lpush      = w_in_play & L & ~R;
    assign w_rpush      = w_in_play & R & ~L;
    assign w_lpoint     = w_lpush & leftEnd;
    assign w_rpoint     = w_rpush & rightEnd;
    assign w_lscore_inc = r_lscore + 1'b1;
    assign w_rscore_inc = r_rscore + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= START;
            r_hold   <= '0;
            r_lscore <= '0;
            r_rscore <= '0;
            r_winner <= 2'b00;
        end else begin
            r_state  <= w_state_next;
            r_hold   <= w_hold_next;
            r_lscore <= w_lscore_next;
            r_rscore <= w_rscore_next;
            r_winner <= w_winner_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_hold_next   = r_hold;
        w_lscore_next = r_lscore;
        w_rscore_next = r_rscore;
        w_winner_next = r_winner;
        case (r_state)
            START: w_state_next = PLAY;
            PLAY: begin
                if (w_lpoint) begin
                    w_lscore_next = w_lscore_inc;
                    if (w_lscore_inc == MATCH_PTS) begin
                        w_state_next  = DONE;
                        w_winner_next = 2'b10;
                    end else begin
                        w_state_next = HOLD;
                        w_hold_next  = HOLD_LOAD;
                    end
                end else if (w_rpoint) begin
                    w_rscore_next = w_rscore_inc;
                    if (w_rscore_inc == MATCH_PTS) begin
                        w_state_next  = DONE;
                        w_winner_next = 2'b01;
                    end else begin
                        w_state_next = HOLD;
                        w_hold_next  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (r_hold == '0) begin
                    w_state_next = START;
                end else begin
                    w_hold_next = r_hold - 1'b1;
                end
            end
            DONE: w_state_next = DONE;
            default: w_state_next = START;
        endcase
    end

    // Field pushes and playing are masked by reset so the field sees nothing while held.
    assign fieldL     = w_lpush & ~reset;
    assign fieldR     = w_rpush & ~reset;
    assign fieldReset = reset | (r_state == START);
    assign playing    = w_in_play & ~reset;
    assign leftScore  = r_lscore;
    assign rightScore = r_rscore;
    assign winner     = r_winner;

endmodule

// File: doc/tug_referee.md
# tug_referee

Round and match controller for the tug-of-war playfield. It sits between the conditioned player buttons and the chain of field light cells. It gates player pushes into the field and arbitrates simultaneous presses. It detects round wins at the field ends, keeps per-player scores, freezes the field for a hold-off period after each point, re-centres the field by pulsing the field reset, and latches the match winner.

## Interface
Parameters:
- HOLD_CYCLES, 8: freeze length after a point, in clk cycles; must be ≥1.
- MATCH_POINTS, 7: points needed to win the match; must be in 1..2^SCORE_W−1.
- SCORE_W, 3: width of each score counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high; clears scores and winner and restarts the match.
- L  in  1  left player press, a one-cycle pulse that is already synchronised and edge-detected.
- R  in  1  right player press, a one-cycle pulse that is already synchronised and edge-detected.
- leftEnd  in  1  the leftmost field light is lit.
- rightEnd  in  1  the rightmost field light is lit.
- fieldL  out  1  gated left push to the field cells.
- fieldR  out  1  gated right push to the field cells.
- fieldReset  out  1  reset to all field cells; re-centres the light.
- leftScore  out  SCORE_W  left player's points.
- rightScore  out  SCORE_W  right player's points.
- winner  out  2  match result: 2'b00 = none, 2'b10 = left, 2'b01 = right.
- playing  out  1  high while in the PLAY state.

## Operation
- States: START, PLAY, HOLD, DONE. Reset forces the state to START.
- Push arbitration, PLAY only:
  - fieldL = L & !R.
  - fieldR = R & !L.
  - L & R in the same cycle cancels both: no push and no win.
  - In START, HOLD and DONE, fieldL and fieldR are both 0.
- Win condition in PLAY:
  - Left scores a point when leftEnd & L & !R.
  - Right scores a point when rightEnd & R & !L.
  - leftEnd and rightEnd both high is illegal. If it occurs, only the arbitrated press decides which player scores.
- START: fieldReset = 1 for exactly one cycle, then go to PLAY unconditionally.
- PLAY → on a left point:
  - leftScore increments.
  - If the new value equals MATCH_POINTS, go to DONE and set winner = 2'b10.
  - Otherwise go to HOLD and load the hold counter with HOLD_CYCLES−1.
- PLAY → on a right point: symmetric, setting winner = 2'b01.
- PLAY with no point: stay in PLAY.
- HOLD:
  - All presses are ignored; the field is frozen and shows the end light.
  - The hold counter decrements each cycle. When it reaches 0, go to START.
- DONE:
  - Terminal state. The field is frozen and fieldReset = 0, so the final field picture stays visible.
  - Scores and winner hold their values.
  - Only reset leaves DONE.
- fieldReset = reset | (state == START). The field is therefore also held in reset while reset is asserted.
- Scores never wrap. The maximum reachable value is MATCH_POINTS, because the match ends there.
- The hold counter is wide enough to hold HOLD_CYCLES−1.

## Timing
- Values during and after reset:
  - While reset = 1: fieldReset = 1, fieldL = fieldR = 0, playing = 0.
  - Clock edge with reset = 1: state = START, both scores = 0, winner = 0, hold counter = 0.
  - First cycle after reset deasserts: START, fieldReset = 1.
  - Second cycle after reset deasserts: PLAY, playing = 1.
- fieldL and fieldR are combinational from the state and L/R, so a push reaches the field in the same cycle as the press.
- Point scored in cycle N:
  - Score and state update at the end of cycle N; the new score is visible in cycle N+1.
  - HOLD occupies cycles N+1 .. N+HOLD_CYCLES.
  - START occupies cycle N+HOLD_CYCLES+1.
  - PLAY resumes at cycle N+HOLD_CYCLES+2.
- Match point in cycle N: DONE from cycle N+1 onward; winner is valid from cycle N+1.
- Reset mid-HOLD or mid-DONE takes effect at the next edge: scores are cleared and the block returns to START. Any in-progress hold count is discarded.
- A press in the last HOLD cycle or in the START cycle is dropped; it is not queued.

## Test plan
- Reset then idle, default parameters: fieldReset high for the reset cycles plus 1 cycle, then playing = 1; scores 0/0, winner 00.
- In PLAY, pulse L with leftEnd = 0: fieldL = 1 in that cycle and fieldR = 0; no score change. Pulse L and R together: fieldL = fieldR = 0.
- leftEnd = 1 and pulse L in cycle N: leftScore = 1 at N+1; playing = 0 for 8 cycles; fieldReset = 1 at N+9; playing = 1 at N+10. Presses during HOLD give fieldL = fieldR = 0 and no score change.
- Right scores 7 points (each point: rightEnd & R): after the 7th, rightScore = 7, winner = 01, and the block stays in DONE for 20 further cycles despite presses, with fieldReset = 0.
- leftEnd & rightEnd & L & R in the same cycle: no score and no state change.
- Reset asserted mid-HOLD with score 3/2: next cycle scores 0/0, winner 00, START then PLAY.
